alu_stack_seq: RTL and testbench

Operand-stack sequencer for the 16-bit stack-processor ALU. It holds a small LIFO operand stack and accepts push, pop, peek and ALU commands over a valid/ready interface. For ALU commands it pops the operands, drives the external combinational ALU (Oper/A/B), captures ALU_Out and Overflow, and pushes the result. It sits between instruction decode and the ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_stack_seq.sv | 138 +++++++++++++
 tb/tb_alu_stack_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stack_seq.sv
// Operand-stack sequencer for the 16-bit stack ALU: LIFO operand stack with
// push/pop/peek/ALU commands; drives an external combinational ALU.
module alu_stack_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     Cmd_Valid,
  output logic                     Cmd_Ready,
  input  logic [1:0]               Cmd,
  input  logic [3:0]               Cmd_Oper,
  input  logic [WIDTH-1:0]         Cmd_Data,
  output logic                     Rsp_Valid,
  output logic [WIDTH-1:0]         Rsp_Data,
  output logic                     Rsp_Err,
  output logic                     Rsp_Ovf,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic [3:0]               Oper,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  input  logic [WIDTH-1:0]         ALU_Out,
  input  logic                     Overflow
);

  // state | meaning
  // IDLE  | ready for a command; push/pop/peek/rejects respond next cycle
  // EXEC  | ALU operands registered; capture ALU_Out at the end of this cycle
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_POP  = 2'b01;
  localparam logic [1:0] CMD_ALU  = 2'b10;
  localparam logic [1:0] CMD_PEEK = 2'b11;
  localparam logic [3:0] OP_ZERO  = 4'd8;
  localparam logic [3:0] OP_MAX   = 4'd9;

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [AW-1:0]    tos_idx, nos_idx, push_idx, wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en, accept, full, empty, unary, alu_ok;

  assign tos_idx  = AW'(Depth - DW'(1));
  assign nos_idx  = AW'(Depth - DW'(2));
  assign push_idx = Depth[AW-1:0];
  assign full     = (Depth == DW'(DEPTH));
  assign empty    = (Depth == '0);
  assign unary    = (Cmd_Oper == OP_ZERO);
  assign alu_ok   = (Cmd_Oper <= OP_MAX) && (unary ? !empty : (Depth >= DW'(2)));

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign Cmd_Ready = reset_n && (state == IDLE);
  assign accept    = Cmd_Valid && Cmd_Ready;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    wr_data = Cmd_Data;
    if (accept && (Cmd == CMD_PUSH) && !full) begin
      wr_en = 1'b1;
    end else if (state == EXEC) begin
      wr_en   = 1'b1;
      wr_idx  = (Oper == OP_ZERO) ? tos_idx : nos_idx;
      wr_data = ALU_Out;
    end
  end

  // Stack storage needs no reset; contents are meaningless at Depth=0.
  always_ff @(posedge clk) begin
    if (wr_en) stack_mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      Rsp_Valid <= 1'b0;
      Rsp_Data  <= '0;
      Rsp_Err   <= 1'b0;
      Rsp_Ovf   <= 1'b0;
      Depth     <= '0;
      Oper      <= '0;
      A         <= '0;
      B         <= '0;
    end else begin
      Rsp_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (Cmd)
              CMD_PUSH: begin
                Rsp_Valid <= 1'b1;
                Rsp_Ovf   <= 1'b0;
                Rsp_Err   <= full;
                Rsp_Data  <= full ? '0 : Cmd_Data;
                if (!full) Depth <= Depth + DW'(1);
              end
              CMD_POP, CMD_PEEK: begin
                Rsp_Valid <= 1'b1;
                Rsp_Ovf   <= 1'b0;
                Rsp_Err   <= empty;
                Rsp_Data  <= empty ? '0 : stack_mem[tos_idx];
                if (!empty && (Cmd == CMD_POP)) Depth <= Depth - DW'(1);
              end
              CMD_ALU: begin
                if (alu_ok) begin
                  Oper  <= Cmd_Oper;
                  A     <= unary ? stack_mem[tos_idx] : stack_mem[nos_idx];
                  B     <= unary ? '0 : stack_mem[tos_idx];
                  state <= EXEC;
                end else begin
                  Rsp_Valid <= 1'b1;
                  Rsp_Err   <= 1'b1;
                  Rsp_Ovf   <= 1'b0;
                  Rsp_Data  <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          Rsp_Valid <= 1'b1;
          Rsp_Err   <= 1'b0;
          Rsp_Data  <= ALU_Out;
          Rsp_Ovf   <= Overflow;
          if (Oper != OP_ZERO) Depth <= Depth - DW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stack_seq.sv
// Directed bench for alu_stack_seq with a behavioural model of the external ALU.
module tb_alu_stack_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic [1:0]  Cmd = 2'b00;
  logic [3:0]  Cmd_Oper = 4'd0;
  logic [15:0] Cmd_Data = 16'd0;
  logic        Rsp_Valid;
  logic [15:0] Rsp_Data;
  logic        Rsp_Err;
  logic        Rsp_Ovf;
  logic [3:0]  Depth;
  logic [3:0]  Oper;
  logic [15:0] A, B;
  logic [15:0] ALU_Out;
  logic        Overflow;
  logic [16:0] alu_res;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat, rdy_low;
  logic [15:0] r_data;
  logic r_err, r_ovf;

  alu_stack_seq #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd(Cmd), .Cmd_Oper(Cmd_Oper), .Cmd_Data(Cmd_Data), .Rsp_Valid(Rsp_Valid),
    .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err), .Rsp_Ovf(Rsp_Ovf), .Depth(Depth),
    .Oper(Oper), .A(A), .B(B), .ALU_Out(ALU_Out), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  // External ALU: carry/borrow out reported as Overflow.
  always_comb begin
    alu_res = 17'd0;
    case (Oper)
      4'd0: alu_res = {1'b0, A} + {1'b0, B};
      4'd1: alu_res = {1'b0, A} - {1'b0, B};
      4'd2: alu_res = {1'b0, A & B};
      4'd3: alu_res = {1'b0, A | B};
      4'd4: alu_res = {1'b0, A ^ B};
      4'd5: alu_res = {1'b0, A};
      4'd6: alu_res = {1'b0, B};
      4'd7: alu_res = {16'd0, A == B};
      4'd8: alu_res = {16'd0, A == 16'd0};
      4'd9: alu_res = {16'd0, B < A};
      default: alu_res = 17'd0;
    endcase
  end
  assign ALU_Out  = alu_res[15:0];
  assign Overflow = alu_res[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    Cmd_Valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offers one command, then waits (bounded) for the response pulse.
  task automatic issue(input logic [1:0] c, input logic [3:0] op, input logic [15:0] d);
    @(negedge clk);
    Cmd = c; Cmd_Oper = op; Cmd_Data = d; Cmd_Valid = 1'b1;
    @(posedge clk);
    #1;
    Cmd_Valid = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (!Rsp_Valid && lat < 8) begin
      if (!Cmd_Ready) rdy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!Rsp_Valid) check("rsp_timeout", 32'(Rsp_Valid), 32'd1);
    r_data = Rsp_Data;
    r_err  = Rsp_Err;
    r_ovf  = Rsp_Ovf;
  endtask

  task automatic push(input logic [15:0] d);
    issue(2'b00, 4'd0, d);
  endtask

  initial begin
    // Reset state while held
    #12;
    check("rst_depth", 32'(Depth), 32'd0);
    check("rst_ready", 32'(Cmd_Ready), 32'd0);
    check("rst_valid", 32'(Rsp_Valid), 32'd0);
    do_reset();
    check("rel_ready", 32'(Cmd_Ready), 32'd1);

    // Add with latency/ready timing
    push(16'h0006);
    check("push_lat", 32'(lat), 32'd1);
    push(16'h0009);
    issue(2'b10, 4'd0, 16'h0);
    check("add_data", 32'(r_data), 32'h000F);
    check("add_ovf", 32'(r_ovf), 32'd0);
    check("add_depth", 32'(Depth), 32'd1);
    check("add_lat", 32'(lat), 32'd2);
    check("add_rdylow", 32'(rdy_low), 32'd1);
    check("add_ab", {A, B}, 32'h0006_0009);

    // Sub, then add with carry out
    do_reset();
    push(16'h0000);
    push(16'h0001);
    issue(2'b10, 4'd1, 16'h0);
    check("sub_data", 32'(r_data), 32'hFFFF);
    push(16'h0001);
    issue(2'b10, 4'd0, 16'h0);
    check("ovf_data", 32'(r_data), 32'h0000);
    check("ovf_flag", 32'(r_ovf), 32'd1);
    check("ovf_depth", 32'(Depth), 32'd1);

    // Comparisons
    do_reset();
    push(16'hDEAF);
    push(16'hDEAD);
    issue(2'b10, 4'd9, 16'h0);
    check("lt_data", 32'(r_data), 32'h0001);
    push(16'h0ABC);
    push(16'h0ABC);
    issue(2'b10, 4'd7, 16'h0);
    check("eq_data", 32'(r_data), 32'h0001);
    check("eq_depth", 32'(Depth), 32'd2);
    push(16'hCA11);
    issue(2'b10, 4'd8, 16'h0);
    check("z_data", 32'(r_data), 32'h0000);
    check("z_depth", 32'(Depth), 32'd3);
    check("z_ab", {A, B}, 32'hCA11_0000);
    issue(2'b11, 4'd0, 16'h0);
    check("peek_res", 32'(r_data), 32'h0000);

    // Full and empty boundaries
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    check("full_depth", 32'(Depth), 32'd8);
    push(16'hFFFF);
    check("ovr_err", 32'(r_err), 32'd1);
    check("ovr_depth", 32'(Depth), 32'd8);
    for (int i = 8; i >= 1; i--) begin
      issue(2'b01, 4'd0, 16'h0);
      check("pop_data", 32'(r_data), 32'(i));
      check("pop_err", 32'(r_err), 32'd0);
    end
    issue(2'b01, 4'd0, 16'h0);
    check("udr_err", 32'(r_err), 32'd1);
    check("udr_data", 32'(r_data), 32'd0);
    check("udr_depth", 32'(Depth), 32'd0);

    // Rejected commands
    do_reset();
    issue(2'b11, 4'd0, 16'h0);
    check("peek0_err", 32'(r_err), 32'd1);
    check("peek0_lat", 32'(lat), 32'd1);
    push(16'h0005);
    issue(2'b10, 4'd8, 16'h0);
    check("z5_data", 32'(r_data), 32'd0);
    issue(2'b10, 4'd0, 16'h0);
    check("d1_err", 32'(r_err), 32'd1);
    check("d1_lat", 32'(lat), 32'd1);
    check("d1_rdylow", 32'(rdy_low), 32'd0);
    check("d1_oper", 32'(Oper), 32'd8);
    check("d1_depth", 32'(Depth), 32'd1);
    push(16'h0007);
    issue(2'b10, 4'hA, 16'h0);
    check("badop_err", 32'(r_err), 32'd1);
    check("badop_lat", 32'(lat), 32'd1);
    check("badop_oper", 32'(Oper), 32'd8);
    check("badop_a", 32'(A), 32'h0005);
    check("badop_depth", 32'(Depth), 32'd2);
    issue(2'b01, 4'd0, 16'h0);
    check("after_pop", 32'(r_data), 32'h0007);

    // Reset during EXEC
    do_reset();
    push(16'hAAAA);
    push(16'hBBBB);
    @(negedge clk);
    Cmd = 2'b10; Cmd_Oper = 4'd4; Cmd_Valid = 1'b1;
    @(posedge clk);
    #1;
    Cmd_Valid = 1'b0;
    check("exec_ready", 32'(Cmd_Ready), 32'd0);
    check("exec_b", 32'(B), 32'hBBBB);
    #2;
    reset_n = 1'b0;
    #1;
    check("rx_depth", 32'(Depth), 32'd0);
    check("rx_oper", 32'(Oper), 32'd0);
    check("rx_ab", {A, B}, 32'd0);
    check("rx_ready", 32'(Cmd_Ready), 32'd0);
    @(posedge clk);
    #1;
    check("rx_valid", 32'(Rsp_Valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rx_rel_ready", 32'(Cmd_Ready), 32'd1);
    check("rx_rel_valid", 32'(Rsp_Valid), 32'd0);
    push(16'h1234);
    check("rx_push", 32'(r_data), 32'h1234);
    check("rx_push_depth", 32'(Depth), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
